axis_error_filter_pkt: RTL

//  Single-clock packet-buffering error filter for unthrottled sources (MAC/PHY rx), successor to the CDC filter.

---
 rtl/axis_error_filter_pkg.sv | 8 +
 rtl/axis_filter_ram.sv | 19 +
 rtl/axis_error_filter_pkt.sv | 113 +++++++++++
 3 files changed

// File: rtl/axis_error_filter_pkg.sv
// axis_error_filter_pkg: shared types for the packet-buffering error filter
package axis_error_filter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DISCARD} wr_state_t;
    typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ERR, CAUSE_OVF, CAUSE_LEN} drop_cause_t;
    function automatic drop_cause_t drop_cause(input logic err, input logic ovf, input logic len);
        return err ? CAUSE_ERR : ovf ? CAUSE_OVF : len ? CAUSE_LEN : CAUSE_NONE;
    endfunction
endpackage

// File: rtl/axis_filter_ram.sv
// axis_filter_ram: simple dual-port beat store, one write port and one registered read port
module axis_filter_ram #(
    parameter int AW = 8,
    parameter int W  = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/axis_error_filter_pkt.sv
// axis_error_filter_pkt: buffers rx beats and forwards only cleanly terminated packets
module axis_error_filter_pkt import axis_error_filter_pkg::*; #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int LOG2_DEPTH     = 8,
    parameter int MAX_PKT_LEN    = 1518,
    parameter int CNT_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      i_valid,
    input  logic                      i_last,
    input  logic [AXIS_BYTES*8-1:0]   i_data,
    input  logic [AXIS_USER_BITS-1:0] i_user,
    input  logic                      i_error,
    input  logic                      axis_o_tready,
    output logic                      axis_o_tvalid,
    output logic                      axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
    output logic                      o_drop,
    output logic [1:0]                o_drop_cause,
    output logic [CNT_BITS-1:0]       o_pkts_ok,
    output logic [CNT_BITS-1:0]       o_pkts_dropped,
    output logic [LOG2_DEPTH:0]       o_level
);
    localparam int DW = AXIS_BYTES * 8;
    localparam int W  = DW + AXIS_USER_BITS + 1;
    localparam int PW = LOG2_DEPTH + 1;
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam logic [PW-1:0] DEPTH = PW'(2**LOG2_DEPTH);

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic [CW-1:0] beat_cnt;
    wr_state_t     state;
    drop_cause_t   cause;
    logic          full, too_long, accepting, drop, wr_en;
    logic          s1_valid, rd_en, load_out;
    logic [W-1:0]  rd_data;

    // rd_ptr only advances on a downstream handshake, so prefetched beats still occupy space
    assign full      = (wr_ptr - rd_ptr) == DEPTH;
    assign too_long  = beat_cnt == CW'(MAX_PKT_LEN);
    assign accepting = i_valid && state != ST_DISCARD;
    assign drop      = accepting && (i_error || full || too_long);
    assign wr_en     = accepting && !drop;
    assign cause     = drop_cause(i_error, full, too_long);
    assign o_level   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state          <= ST_IDLE;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            beat_cnt       <= '0;
            o_drop         <= 1'b0;
            o_drop_cause   <= CAUSE_NONE;
            o_pkts_ok      <= '0;
            o_pkts_dropped <= '0;
        end else begin
            o_drop       <= drop;
            o_drop_cause <= drop ? cause : CAUSE_NONE;
            if (drop) begin
                wr_ptr   <= commit_ptr;
                beat_cnt <= '0;
                state    <= i_last ? ST_IDLE : ST_DISCARD;
                if (o_pkts_dropped != '1) o_pkts_dropped <= o_pkts_dropped + 1'b1;
            end else if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                beat_cnt <= i_last ? '0 : beat_cnt + 1'b1;
                state    <= i_last ? ST_IDLE : ST_ACTIVE;
                if (i_last) commit_ptr <= wr_ptr + 1'b1;
                if (i_last && o_pkts_ok != '1) o_pkts_ok <= o_pkts_ok + 1'b1;
            end else if (i_valid && i_last) begin
                state    <= ST_IDLE;
                beat_cnt <= '0;
            end
        end
    end

    axis_filter_ram #(.AW(LOG2_DEPTH), .W(W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[LOG2_DEPTH-1:0]),
        .wr_data ({i_last, i_user, i_data}),
        .rd_en   (rd_en),
        .rd_addr (fetch_ptr[LOG2_DEPTH-1:0]),
        .rd_data (rd_data)
    );

    // two-stage prefetch: RAM read register (s1) feeding the output register
    assign load_out = s1_valid && (!axis_o_tvalid || axis_o_tready);
    assign rd_en    = (fetch_ptr != commit_ptr) && (!s1_valid || load_out);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            fetch_ptr     <= '0;
            rd_ptr        <= '0;
            s1_valid      <= 1'b0;
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tuser  <= '0;
            axis_o_tdata  <= '0;
        end else begin
            if (rd_en) fetch_ptr <= fetch_ptr + 1'b1;
            s1_valid <= rd_en || (s1_valid && !load_out);
            if (load_out) {axis_o_tlast, axis_o_tuser, axis_o_tdata} <= rd_data;
            if (load_out) axis_o_tvalid <= 1'b1;
            else if (axis_o_tready) axis_o_tvalid <= 1'b0;
            if (axis_o_tvalid && axis_o_tready) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule
